// File: rtl/spi_master_pkg.sv
// Shared types and helpers for the SPI mode-0 master.
package spi_master_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StLead  = 3'd1,
        StHigh  = 3'd2,
        StLow   = 3'd3,
        StTrail = 3'd4,
        StGap   = 3'd5
    } state_e;

    // Largest of three hold lengths; sizes the shared divider counter.
    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/spi_master_if.sv
// Host-side handshake and SPI pin bundle for spi_master.
interface spi_master_if #(
    parameter int unsigned p_WORD_LEN = 8
);
    logic [p_WORD_LEN-1:0] i_data;
    logic                  i_dv;
    logic                  o_ready;
    logic                  o_busy;
    logic [p_WORD_LEN-1:0] o_data;
    logic                  o_dv;
    logic                  o_sclk;
    logic                  o_mosi;
    logic                  o_ss;
    logic                  i_miso;

    modport master (
        input  i_data, i_dv, i_miso,
        output o_ready, o_busy, o_data, o_dv, o_sclk, o_mosi, o_ss
    );

    modport slave (
        output i_data, i_dv, i_miso,
        input  o_ready, o_busy, o_data, o_dv, o_sclk, o_mosi, o_ss
    );
endinterface

// File: rtl/spi_master_clk_div.sv
// Loadable down-counter; o_tc is high while the count sits at zero. Never wraps.
module spi_master_clk_div #(
    parameter int unsigned p_CNT_W = 3
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_load,
    input  logic [p_CNT_W-1:0] i_load_val,
    output logic               o_tc
);
    logic [p_CNT_W-1:0] cnt_q, cnt_d;

    // Next count: load wins, otherwise count down and stop at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (i_load) begin
            cnt_d = i_load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - p_CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_tc = (cnt_q == '0);
endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master: one word per accepted request, MSB first by default.
// Define SPI_MASTER_LSB_FIRST_EN to shift LSB first in both directions.
module spi_master
    import spi_master_pkg::*;
#(
    parameter int unsigned p_WORD_LEN = 8,
    parameter int unsigned p_CLK_DIV  = 4,
    parameter int unsigned p_CS_SETUP = 4,
    parameter int unsigned p_CS_GAP   = 4
) (
    input logic          i_clk,
    input logic          i_rst,
    spi_master_if.master bus
);
    localparam int unsigned DivW = $clog2(max3(p_CLK_DIV, p_CS_SETUP, p_CS_GAP) + 1);
    localparam int unsigned BitW = $clog2(p_WORD_LEN + 1);
    // Divider reload values: a state held N cycles reloads N-1.
    localparam logic [DivW-1:0] SetupLd = DivW'(p_CS_SETUP - 1);
    localparam logic [DivW-1:0] HalfLd  = DivW'(p_CLK_DIV - 1);
    localparam logic [DivW-1:0] GapLd   = DivW'(p_CS_GAP - 1);

    state_e                state_q, state_d;
    logic [p_WORD_LEN-1:0] sr_q, sr_d;
    logic [BitW-1:0]       bit_cnt_q, bit_cnt_d;
    logic                  sclk_q, sclk_d;
    logic                  mosi_q, mosi_d;
    logic                  ss_q, ss_d;
    logic [p_WORD_LEN-1:0] data_q, data_d;
    logic                  dv_q, dv_d;

    logic                  div_load;
    logic [DivW-1:0]       div_val;
    logic                  div_tc;

    logic                  first_bit;
    logic                  next_bit;
    logic [p_WORD_LEN-1:0] sr_shifted;

`ifdef SPI_MASTER_LSB_FIRST_EN
    assign first_bit  = bus.i_data[0];
    assign next_bit   = sr_q[0];
    assign sr_shifted = {bus.i_miso, sr_q[p_WORD_LEN-1:1]};
`else
    assign first_bit  = bus.i_data[p_WORD_LEN-1];
    assign next_bit   = sr_q[p_WORD_LEN-1];
    assign sr_shifted = {sr_q[p_WORD_LEN-2:0], bus.i_miso};
`endif

    spi_master_clk_div #(
        .p_CNT_W (DivW)
    ) u_clk_div (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (div_load),
        .i_load_val (div_val),
        .o_tc       (div_tc)
    );

    // Next-state, shift and pin logic; every state change reloads the divider.
    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        bit_cnt_d = bit_cnt_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        ss_d      = ss_q;
        data_d    = data_q;
        dv_d      = 1'b0;
        div_load  = 1'b0;
        div_val   = '0;
        unique case (state_q)
            StIdle: begin
                if (bus.i_dv) begin
                    sr_d      = bus.i_data;
                    ss_d      = 1'b0;
                    mosi_d    = first_bit;
                    bit_cnt_d = BitW'(p_WORD_LEN);
                    div_load  = 1'b1;
                    div_val   = SetupLd;
                    state_d   = StLead;
                end
            end
            StLead, StLow: begin
                if (div_tc) begin
                    // Rising edge: sample miso on the same cycle sclk goes high.
                    sclk_d    = 1'b1;
                    sr_d      = sr_shifted;
                    bit_cnt_d = bit_cnt_q - BitW'(1);
                    div_load  = 1'b1;
                    div_val   = HalfLd;
                    state_d   = StHigh;
                end
            end
            StHigh: begin
                if (div_tc) begin
                    sclk_d   = 1'b0;
                    div_load = 1'b1;
                    div_val  = HalfLd;
                    if (bit_cnt_q != '0) begin
                        mosi_d  = next_bit;
                        state_d = StLow;
                    end else begin
                        state_d = StTrail;
                    end
                end
            end
            StTrail: begin
                if (div_tc) begin
                    ss_d     = 1'b1;
                    data_d   = sr_q;
                    dv_d     = 1'b1;
                    div_load = 1'b1;
                    div_val  = GapLd;
                    state_d  = StGap;
                end
            end
            StGap: begin
                if (div_tc) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers; reset aborts any transfer in flight.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= StIdle;
            sr_q      <= '0;
            bit_cnt_q <= '0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            ss_q      <= 1'b1;
            data_q    <= '0;
            dv_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            ss_q      <= ss_d;
            data_q    <= data_d;
            dv_q      <= dv_d;
        end
    end

    assign bus.o_ready = (state_q == StIdle);
    assign bus.o_busy  = (state_q != StIdle);
    assign bus.o_sclk  = sclk_q;
    assign bus.o_mosi  = mosi_q;
    assign bus.o_ss    = ss_q;
    assign bus.o_data  = data_q;
    assign bus.o_dv    = dv_q;
endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master with a behavioural SPI slave model.
module tb_spi_master;
    localparam int unsigned W   = 8;
    localparam int unsigned D   = 4;
    localparam int unsigned S   = 4;
    localparam int unsigned G   = 4;
    localparam int unsigned Lat = S + (2 * W - 1) * D + D + 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_master_if #(.p_WORD_LEN(W)) bus ();

    spi_master #(
        .p_WORD_LEN (W),
        .p_CLK_DIV  (D),
        .p_CS_SETUP (S),
        .p_CS_GAP   (G)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int exp_dv = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Position in the word of the i-th bit on the wire.
    function automatic int unsigned bit_pos(input int unsigned i);
`ifdef SPI_MASTER_LSB_FIRST_EN
        return i;
`else
        return W - 1 - i;
`endif
    endfunction

    // Slave model and pin monitor, evaluated on the falling clock edge.
    logic [W-1:0] slave_word = '0;
    logic [W-1:0] mosi_word  = '0;
    logic         first_mosi = 1'b0;
    int unsigned  rise_cnt   = 0;
    int unsigned  miso_idx   = 0;
    int           dv_cnt     = 0;
    int           sclk_ss_err = 0;
    int           ss_high_run = 0;
    int           last_gap    = 0;

    initial begin
        logic prev_ss;
        logic prev_sclk;
        prev_ss    = 1'b1;
        prev_sclk  = 1'b0;
        bus.i_miso = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.o_sclk && bus.o_ss) sclk_ss_err++;
            if (bus.o_dv) dv_cnt++;
            if (prev_ss && !bus.o_ss) begin
                last_gap   = ss_high_run;
                rise_cnt   = 0;
                miso_idx   = 0;
                mosi_word  = '0;
                bus.i_miso = slave_word[bit_pos(0)];
            end
            if (bus.o_ss) ss_high_run++;
            else ss_high_run = 0;
            if (!bus.o_ss && !prev_sclk && bus.o_sclk) begin
                if (rise_cnt == 0) first_mosi = bus.o_mosi;
                if (rise_cnt < W) mosi_word[bit_pos(rise_cnt)] = bus.o_mosi;
                rise_cnt++;
            end
            if (!bus.o_ss && prev_sclk && !bus.o_sclk) begin
                miso_idx++;
                if (miso_idx < W) bus.i_miso = slave_word[bit_pos(miso_idx)];
            end
            prev_ss   = bus.o_ss;
            prev_sclk = bus.o_sclk;
        end
    end

    // Main flow acts just after the monitor on each falling edge.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!bus.o_ready && n < 300) begin
            tick();
            n++;
        end
        if (!bus.o_ready) check("ready_wait", bus.o_ready, 1);
    endtask

    task automatic wait_dv(output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!bus.o_dv && lat < 500);
        if (!bus.o_dv) check("dv_wait", bus.o_dv, 1);
    endtask

    // One complete transfer; i_data is scrambled after acceptance.
    task automatic xfer(input logic [W-1:0] tx, input logic [W-1:0] sw,
                        output logic [W-1:0] rx, output int lat);
        slave_word = sw;
        wait_ready();
        bus.i_data = tx;
        bus.i_dv   = 1'b1;
        tick();
        bus.i_dv   = 1'b0;
        bus.i_data = ~tx;
        lat = 1;
        while (!bus.o_dv && lat < 500) begin
            tick();
            lat++;
        end
        if (!bus.o_dv) check("dv_wait", bus.o_dv, 1);
        else exp_dv++;
        rx = bus.o_data;
    endtask

    typedef struct {
        logic [W-1:0] tx;
        logic [W-1:0] sw;
        logic [W-1:0] exp_rx;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] rx;
        logic [W-1:0] tx;
        logic [W-1:0] sw;
        int           lat;
        int           dv0;
        int           n;

        vecs[0] = '{8'hA5, 8'h3C, 8'h3C};
        vecs[1] = '{8'h00, 8'hFF, 8'hFF};
        vecs[2] = '{8'hFF, 8'h00, 8'h00};
        vecs[3] = '{8'h81, 8'h7E, 8'h7E};
        vecs[4] = '{8'h5A, 8'hA5, 8'hA5};

        rst        = 1'b1;
        bus.i_dv   = 1'b0;
        bus.i_data = '0;
        repeat (3) tick();
        check("rst_ss", bus.o_ss, 1);
        check("rst_sclk", bus.o_sclk, 0);
        check("rst_mosi", bus.o_mosi, 0);
        check("rst_dv", bus.o_dv, 0);
        check("rst_data", bus.o_data, 0);
        check("rst_ready", bus.o_ready, 1);
        check("rst_busy", bus.o_busy, 0);
        rst = 1'b0;
        repeat (2) tick();

        // Directed words: loopback values, edge count, latency, single pulse.
        for (int i = 0; i < 5; i++) begin
            dv0 = dv_cnt;
            xfer(vecs[i].tx, vecs[i].sw, rx, lat);
            check("vec_rx", rx, vecs[i].exp_rx);
            check("vec_mosi", mosi_word, vecs[i].tx);
            check("vec_first_mosi", first_mosi, vecs[i].tx[bit_pos(0)]);
            check("vec_rises", rise_cnt, W);
            check("vec_latency", lat, Lat);
            tick();
            check("vec_dv_pulse", bus.o_dv, 0);
            check("vec_data_hold", bus.o_data, vecs[i].exp_rx);
            check("vec_dv_count", dv_cnt - dv0, 1);
        end

        // i_dv held high across two transfers.
        slave_word = 8'h96;
        wait_ready();
        bus.i_data = 8'hFF;
        bus.i_dv   = 1'b1;
        repeat (6) tick();
        bus.i_data = 8'h00;
        wait_dv(lat);
        if (bus.o_dv) exp_dv++;
        check("held1_rx", bus.o_data, 8'h96);
        check("held1_mosi", mosi_word, 8'hFF);
        slave_word = 8'h69;
        wait_ready();
        tick();
        check("held2_accepted", bus.o_busy, 1);
        bus.i_dv = 1'b0;
        wait_dv(lat);
        if (bus.o_dv) exp_dv++;
        check("held2_rx", bus.o_data, 8'h69);
        check("held2_mosi", mosi_word, 8'h00);
        check("held_cs_gap", (last_gap >= G) ? 1 : 0, 1);

        // Reset while sclk is high on the fourth bit.
        slave_word = 8'hE7;
        wait_ready();
        bus.i_data = 8'hA5;
        bus.i_dv   = 1'b1;
        tick();
        bus.i_dv = 1'b0;
        n = 0;
        while (!(rise_cnt == 4 && bus.o_sclk) && n < 300) begin
            tick();
            n++;
        end
        check("rst_mid_reached", bus.o_sclk, 1);
        dv0 = dv_cnt;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_ss", bus.o_ss, 1);
        check("rst_mid_sclk", bus.o_sclk, 0);
        check("rst_mid_dv", bus.o_dv, 0);
        check("rst_mid_ready", bus.o_ready, 1);
        check("rst_mid_busy", bus.o_busy, 0);
        check("rst_mid_data", bus.o_data, 0);
        xfer(8'h81, 8'h3C, rx, lat);
        check("post_rst_rx", rx, 8'h3C);
        check("post_rst_mosi", mosi_word, 8'h81);
        check("post_rst_latency", lat, Lat);
        check("post_rst_dv_count", dv_cnt - dv0, 1);

        // Request pulsed while busy is dropped.
        slave_word = 8'hC5;
        wait_ready();
        dv0 = dv_cnt;
        bus.i_data = 8'h5C;
        bus.i_dv   = 1'b1;
        tick();
        bus.i_dv = 1'b0;
        repeat (10) tick();
        check("busy_high", bus.o_busy, 1);
        bus.i_data = 8'h00;
        bus.i_dv   = 1'b1;
        tick();
        bus.i_dv = 1'b0;
        wait_dv(lat);
        if (bus.o_dv) exp_dv++;
        check("busy_rx", bus.o_data, 8'hC5);
        check("busy_mosi", mosi_word, 8'h5C);
        wait_ready();
        check("idle_busy_low", bus.o_busy, 0);
        repeat (100) tick();
        check("busy_dv_count", dv_cnt - dv0, 1);
        check("busy_still_idle", bus.o_ready, 1);

`ifdef SPI_MASTER_LSB_FIRST_EN
        xfer(8'h01, 8'h80, rx, lat);
        check("lsb_rx", rx, 8'h80);
        check("lsb_first_mosi", first_mosi, 1);
`endif

        // Random words against the model: slave word returns, tx appears on mosi.
        for (int i = 0; i < 24; i++) begin
            tx = W'($urandom);
            sw = W'($urandom);
            xfer(tx, sw, rx, lat);
            check("rand_rx", rx, sw);
            check("rand_mosi", mosi_word, tx);
            check("rand_rises", rise_cnt, W);
            check("rand_latency", lat, Lat);
        end

        wait_ready();
        repeat (10) tick();
        check("sclk_while_ss_high", sclk_ss_err, 0);
        check("total_dv_count", dv_cnt, exp_dv);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
